heichips25_project_mux: RTL

- Parametrised successor to the fixed tiny-wrapper arrangement: multiplexes NUM_PROJECTS tiny-tapeout-style projects onto one shared uo/uio pad set.
- Provides a registered select handshake, glitch-free switching through a guard/drain phase, and per-project enable and reset sequencing.
- Sits between the pad ring and the project instances.

---
 rtl/heichips25_project_mux.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/heichips25_project_mux.sv
// heichips25_project_mux: shares one uo/uio pad set between NUM_PROJECTS
// tiny projects. A select request is accepted through a valid/ready handshake.
// The block then runs a switch sequence: a guard phase (DRAIN) that forces the
// pads off, then a reset phase (PRST) that holds the new project in reset with
// ena high. After that the new project is connected through registered outputs.
// Optional macro HEICHIPS25_MUX_STATUS_EN: drive a status byte on uo_out while
// no project is connected (IDLE, DRAIN and PRST).
module heichips25_project_mux #(
    parameter int NUM_PROJECTS = 4,
    parameter int SEL_W        = 4,
    parameter int GUARD_CYCLES = 4,
    parameter int RST_CYCLES   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sel_valid,
    input  logic [SEL_W-1:0]          sel_id,
    output logic                      sel_ready,
    output logic                      sel_err,
    input  logic [8*NUM_PROJECTS-1:0] proj_uo_out,
    input  logic [8*NUM_PROJECTS-1:0] proj_uio_out,
    input  logic [8*NUM_PROJECTS-1:0] proj_uio_oe,
    output logic [NUM_PROJECTS-1:0]   proj_ena,
    output logic [NUM_PROJECTS-1:0]   proj_rst_n,
    output logic [7:0]                uo_out,
    output logic [7:0]                uio_out,
    output logic [7:0]                uio_oe,
    output logic [SEL_W-1:0]          active_id,
    output logic                      busy
);

    localparam logic [SEL_W:0] NP_LIMIT   = (SEL_W+1)'(NUM_PROJECTS);
    localparam logic [7:0]     GUARD_LOAD = 8'(GUARD_CYCLES);
    localparam logic [7:0]     RST_LOAD   = 8'(RST_CYCLES);

    typedef enum logic [1:0] {IDLE, DRAIN, PRST, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [SEL_W-1:0] pending_id, pending_nxt, active_nxt;
    logic             accept, in_range, err_nxt;
    logic [7:0]       sel_uo, sel_uio, sel_oe;
    logic [7:0]       uo_nxt, uio_nxt, oe_nxt;

    assign sel_ready = (state == IDLE) || (state == ACTIVE);
    assign busy      = (state == DRAIN) || (state == PRST);
    assign accept    = sel_valid && sel_ready;
    assign in_range  = {1'b0, sel_id} < NP_LIMIT;

    // Next-state logic: handshake decode plus the guard and reset countdowns.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending_id;
        active_nxt  = active_id;
        err_nxt     = 1'b0;
        case (state)
            IDLE, ACTIVE: begin
                if (accept) begin
                    if (!in_range) begin
                        err_nxt = 1'b1;
                    end else if ((state == IDLE) || (sel_id != active_id)) begin
                        state_nxt   = DRAIN;
                        cnt_nxt     = GUARD_LOAD;
                        pending_nxt = sel_id;
                    end
                end
            end
            DRAIN: begin
                if (cnt == 8'd1) begin
                    state_nxt  = PRST;
                    cnt_nxt    = RST_LOAD;
                    active_nxt = pending_id;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            PRST: begin
                if (cnt == 8'd1) begin
                    state_nxt = ACTIVE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-project ena/rst_n decode and selection of the active project's buses.
    always_comb begin
        proj_ena   = '0;
        proj_rst_n = '0;
        sel_uo     = 8'h00;
        sel_uio    = 8'h00;
        sel_oe     = 8'h00;
        for (int k = 0; k < NUM_PROJECTS; k++) begin
            if (active_id == SEL_W'(k)) begin
                proj_ena[k]   = (state == PRST) || (state == ACTIVE);
                proj_rst_n[k] = (state == ACTIVE);
                sel_uo        = proj_uo_out[8*k +: 8];
                sel_uio       = proj_uio_out[8*k +: 8];
                sel_oe        = proj_uio_oe[8*k +: 8];
            end
        end
    end

    // Pad values for the next cycle: the project passes through only while it stays active.
    always_comb begin
        uo_nxt  = 8'h00;
        uio_nxt = 8'h00;
        oe_nxt  = 8'h00;
        if ((state == ACTIVE) && (state_nxt == ACTIVE)) begin
            uo_nxt  = sel_uo;
            uio_nxt = sel_uio;
            oe_nxt  = sel_oe;
        end
`ifdef HEICHIPS25_MUX_STATUS_EN
        else if (state_nxt == IDLE) begin
            uo_nxt = {4'hA, 4'(NUM_PROJECTS)};
        end else if ((state_nxt == DRAIN) || (state_nxt == PRST)) begin
            uo_nxt = {4'h5, 4'(pending_nxt)};
        end
`endif
    end

    // State, counters and registered pad outputs; reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            pending_id <= '0;
            active_id  <= '0;
            sel_err    <= 1'b0;
            uo_out     <= 8'h00;
            uio_out    <= 8'h00;
            uio_oe     <= 8'h00;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pending_id <= pending_nxt;
            active_id  <= active_nxt;
            sel_err    <= err_nxt;
            uo_out     <= uo_nxt;
            uio_out    <= uio_nxt;
            uio_oe     <= oe_nxt;
        end
    end

endmodule
